// File: rtl/unified_mem_arbiter.sv
// Sequencer/arbiter sharing the single-port unified I/D memory between IF bundle fetches
// and MEM loads/stores; MEM has priority, a saturating starvation counter forces IF through.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int INSTR_END  = 2048,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [95:0]       if_bundle,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_read,
  input  logic [1:0]        d_write,
  input  logic              d_unsigned,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              d_fault,
  output logic [ADDR_W-1:0] mem_address,
  output logic [1:0]        mem_read,
  output logic [1:0]        mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_unsigned,
  output logic              mem_ifetch,
  input  logic [95:0]       mem_rdata
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]   SMAX = CW'(STARVE_MAX);
  localparam logic [ADDR_W:0] IEND = (ADDR_W + 1)'(INSTR_END);

  typedef enum logic [1:0] {IDLE, IF_RESP, D_RESP} state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          fault_q, flush_seen;
  logic          idle, grant_d, grant_if, store_blk;

  // Grants are combinational so stores commit and reads return within the grant cycle.
  always_comb begin
    idle          = rst_n && (state == IDLE);
    grant_d       = idle && d_req && (!if_req || starve_cnt < SMAX);
    grant_if      = idle && !grant_d && if_req;
    store_blk     = (d_write != 2'b00) && ({1'b0, d_addr} < IEND);
    mem_address   = '0;
    mem_read      = 2'b00;
    mem_write     = 2'b00;
    mem_writedata = '0;
    mem_unsigned  = 1'b0;
    mem_ifetch    = 1'b0;
    if (grant_d) begin
      mem_address   = d_addr;
      mem_read      = d_read;
      mem_write     = store_blk ? 2'b00 : d_write;
      mem_writedata = d_wdata;
      mem_unsigned  = d_unsigned;
    end else if (grant_if) begin
      mem_address = if_addr;
      mem_read    = 2'b11;
      mem_ifetch  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      fault_q    <= 1'b0;
      flush_seen <= 1'b0;
      if_bundle  <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!if_req || grant_if)
            starve_cnt <= '0;
          else if (grant_d && starve_cnt < SMAX)
            starve_cnt <= starve_cnt + CW'(1);
          if (grant_d) begin
            state   <= D_RESP;
            fault_q <= store_blk;
            // a no-op (and a store) returns zero rather than whatever the memory drives
            d_rdata <= (d_read == 2'b00) ? 32'h0 : mem_rdata[31:0];
          end else if (grant_if) begin
            state      <= IF_RESP;
            flush_seen <= if_flush;
            if_bundle  <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign if_done = (state == IF_RESP) && !if_flush && !flush_seen;
  assign d_done  = (state == D_RESP);
  assign d_fault = d_done && fault_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: byte-array memory environment, transaction-level reference memory,
// directed test-plan cases then two concurrent randomized requesters.
module tb_unified_mem_arbiter;
  localparam int ADDR_W = 12, INSTR_END = 2048, STARVE_MAX = 4;

  logic clk = 1'b0, rst_n;
  logic if_req, if_flush, if_done, d_req, d_unsigned, d_done, d_fault;
  logic mem_unsigned, mem_ifetch;
  logic [ADDR_W-1:0] if_addr, d_addr, mem_address;
  logic [1:0] d_read, d_write, mem_read, mem_write;
  logic [31:0] d_wdata, d_rdata, mem_writedata;
  logic [95:0] if_bundle, mem_rdata;

  unified_mem_arbiter #(.ADDR_W(ADDR_W), .INSTR_END(INSTR_END), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_done(if_done), .if_bundle(if_bundle),
    .d_req(d_req), .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_unsigned(d_unsigned),
    .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata), .d_fault(d_fault),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_unsigned(mem_unsigned), .mem_ifetch(mem_ifetch),
    .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  logic [7:0] mem [4096];
  logic [7:0] ref_mem [4096];
  logic load_req;
  int total = 0, bad = 0;

  // memory environment: combinational read with load extension, write at the clock edge
  always_comb begin
    mem_rdata = '0;
    if (mem_ifetch) begin
      for (int i = 0; i < 12; i++) mem_rdata[8*i +: 8] = mem[mem_address + 12'(i)];
    end else begin
      case (mem_read)
        2'b01: mem_rdata[31:0] = {{24{~mem_unsigned & mem[mem_address][7]}}, mem[mem_address]};
        2'b10: mem_rdata[31:0] = {{16{~mem_unsigned & mem[mem_address + 12'd1][7]}},
                                  mem[mem_address + 12'd1], mem[mem_address]};
        2'b11: mem_rdata[31:0] = {mem[mem_address + 12'd3], mem[mem_address + 12'd2],
                                  mem[mem_address + 12'd1], mem[mem_address]};
        default: mem_rdata = '0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 4096; i++) mem[i] <= ref_mem[i];
    end else begin
      if (mem_write != 2'b00) mem[mem_address] <= mem_writedata[7:0];
      if (mem_write[1]) mem[mem_address + 12'd1] <= mem_writedata[15:8];
      if (mem_write == 2'b11) begin
        mem[mem_address + 12'd2] <= mem_writedata[23:16];
        mem[mem_address + 12'd3] <= mem_writedata[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [11:0] a, input logic [1:0] rd, input logic uns);
    int n;
    logic [31:0] v;
    n = (rd == 2'b11) ? 4 : int'(rd);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + 12'(i)];
    if (!uns && n > 0 && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic logic [95:0] ref_bundle(input logic [11:0] a);
    logic [95:0] b;
    for (int i = 0; i < 12; i++) b[8*i +: 8] = ref_mem[a + 12'(i)];
    return b;
  endfunction

  task automatic ref_store(input logic [11:0] a, input logic [1:0] wr, input logic [31:0] wd);
    int n;
    n = (wr == 2'b11) ? 4 : int'(wr);
    for (int i = 0; i < n; i++) ref_mem[a + 12'(i)] = wd[8*i +: 8];
  endtask

  task automatic d_op(input string tag, input logic [11:0] a, input logic [1:0] rd, input logic [1:0] wr,
                      input logic uns, input logic [31:0] wd, input logic [31:0] exp_rd);
    bit got, blk;
    blk = (wr != 2'b00) && (a < 12'(INSTR_END));
    @(negedge clk);
    d_req = 1; d_addr = a; d_read = rd; d_write = wr; d_unsigned = uns; d_wdata = wd;
    #1 check({tag, " mw"}, 96'(mem_write), 96'(blk ? 2'b00 : wr));
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin @(negedge clk); got = d_done; end
    check({tag, " done"}, 96'(got), 96'(1));
    check({tag, " rdata"}, 96'(d_rdata), 96'(exp_rd));
    check({tag, " fault"}, 96'(d_fault), 96'(blk));
    if (wr != 2'b00 && !blk) ref_store(a, wr, wd);
    d_req = 0; d_read = 0; d_write = 0;
  endtask

  task automatic if_op(input string tag, input logic [11:0] a, input logic [95:0] exp);
    bit got;
    @(negedge clk);
    if_req = 1; if_addr = a;
    #1 check({tag, " ifetch"}, 96'(mem_ifetch), 96'(1));
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin @(negedge clk); got = if_done; end
    check({tag, " done"}, 96'(got), 96'(1));
    check({tag, " bundle"}, if_bundle, exp);
    if_req = 0;
  endtask

  // fairness monitor for the random phase: MEM wins in a row while IF waits stay bounded
  logic mon_on = 1'b0, if_req_q;
  int scnt = 0;
  always @(posedge clk) if_req_q <= if_req;
  always @(negedge clk) begin
    if (mon_on) begin
      if (d_done && if_req_q) begin
        scnt++;
        check("starve bound", 96'(scnt <= STARVE_MAX), 96'(1));
      end
      if (if_done || !if_req_q) scnt = 0;
    end
  end

  logic [31:0] prog [3];
  int ndone;

  initial begin
    rst_n = 0; if_req = 1; if_addr = 12'd16; if_flush = 0;
    d_req = 1; d_addr = 12'd16; d_read = 0; d_write = 2'b11; d_unsigned = 0; d_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
    prog[0] = 32'h00a00093; prog[1] = 32'h01400113; prog[2] = 32'h002081b3;
    for (int j = 0; j < 3; j++)
      for (int b = 0; b < 4; b++) ref_mem[4*j + b] = prog[j][8*b +: 8];
    load_req = 1;
    #1;
    check("rst ctrl", 96'({mem_address, mem_read, mem_write, mem_unsigned, mem_ifetch}), 96'(0));
    check("rst wdata", 96'(mem_writedata), 96'(0));
    check("rst done", 96'({if_done, d_done, d_fault}), 96'(0));
    check("rst bundle", if_bundle, 96'(0));
    check("rst rdata", 96'(d_rdata), 96'(0));
    repeat (3) @(negedge clk);
    load_req = 0;
    check("rst hold", 96'({mem_write, mem_read, mem_ifetch, d_done, if_done}), 96'(0));

    rst_n = 1; d_write = 0; d_read = 2'b11; d_addr = 12'h800;
    #1 check("post rst grant", 96'({mem_read, mem_ifetch}), 96'({2'b11, 1'b0}));
    @(negedge clk);
    check("post rst done", 96'(d_done), 96'(1));
    check("post rst rdata", 96'(d_rdata), 96'(ref_load(12'h800, 2'b11, 1'b0)));
    if_req = 0; d_req = 0; d_read = 0;

    if_op("fetch0", 12'd0, 96'h002081b3_01400113_00a00093);
    d_op("sw", 12'd2048, 2'b00, 2'b11, 1'b0, 32'h8000_00F0, 32'h0);
    d_op("lb", 12'd2048, 2'b01, 2'b00, 1'b0, 32'h0, 32'hFFFF_FFF0);
    d_op("lbu", 12'd2048, 2'b01, 2'b00, 1'b1, 32'h0, 32'h0000_00F0);
    d_op("lh", 12'd2050, 2'b10, 2'b00, 1'b0, 32'h0, 32'hFFFF_8000);
    d_op("noop", 12'd2052, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
    d_op("prot sw", 12'd16, 2'b00, 2'b11, 1'b0, 32'hDEAD_BEEF, 32'h0);
    if_op("prot fetch", 12'd16, ref_bundle(12'd16));

    // flush while the fetch response is out
    @(negedge clk); if_req = 1; if_addr = 12'd32;
    @(negedge clk); if_flush = 1; if_req = 0;
    #1 check("flush resp", 96'(if_done), 96'(0));
    @(negedge clk); if_flush = 0;
    if_op("after flush", 12'd32, ref_bundle(12'd32));
    // flush raised in the grant cycle itself
    @(negedge clk); if_req = 1; if_flush = 1; if_addr = 12'd48;
    @(negedge clk); if_flush = 0; if_req = 0;
    #1 check("flush grant", 96'(if_done), 96'(0));
    if_op("after flush2", 12'd48, ref_bundle(12'd48));

    // both requesters held high: four MEM wins, then one IF, repeating
    @(negedge clk);
    d_req = 1; d_addr = 12'h800; d_read = 2'b11; d_write = 0; if_req = 1; if_addr = 12'd0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (d_done || if_done) begin
        check($sformatf("starve kind%0d", ndone), 96'({if_done, d_done}),
              96'((ndone % 5 == 4) ? 2'b10 : 2'b01));
        ndone++;
      end
    end
    check("starve count", 96'(ndone), 96'(10));
    d_req = 0; if_req = 0; d_read = 0;

    mon_on = 1;
    fork
      begin : dproc
        logic [1:0] rd, wr, c;
        logic [11:0] a;
        logic uns, blk;
        logic [31:0] wd;
        bit got;
        int k;
        for (int t = 0; t < 60; t++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          k = $urandom_range(0, 9);
          c = 2'($urandom_range(1, 3));
          rd = (k >= 1 && k <= 5) ? c : 2'b00;
          wr = (k >= 6) ? c : 2'b00;
          a = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 2047)) : 12'($urandom_range(2048, 4095));
          if (c == 2'b10) a[0] = 1'b0;
          if (c == 2'b11) a[1:0] = 2'b00;
          uns = 1'($urandom);
          wd = $urandom;
          blk = (wr != 2'b00) && (a < 12'(INSTR_END));
          d_req = 1; d_addr = a; d_read = rd; d_write = wr; d_unsigned = uns; d_wdata = wd;
          got = 0;
          for (int n = 0; n < 40 && !got; n++) begin @(negedge clk); got = d_done; end
          check("rnd d done", 96'(got), 96'(1));
          check($sformatf("rnd d rdata a=%0h rd=%0d u=%0d", a, rd, uns), 96'(d_rdata),
                96'((rd != 2'b00) ? ref_load(a, rd, uns) : 32'h0));
          check("rnd d fault", 96'(d_fault), 96'(blk));
          if (wr != 2'b00 && !blk) ref_store(a, wr, wd);
          d_req = 0; d_read = 0; d_write = 0;
        end
      end
      begin : iproc
        logic [11:0] a;
        bit got;
        for (int t = 0; t < 40; t++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a = 12'($urandom_range(0, 1021) * 4);
          if_req = 1; if_addr = a;
          got = 0;
          for (int n = 0; n < 40 && !got; n++) begin @(negedge clk); got = if_done; end
          check("rnd if done", 96'(got), 96'(1));
          check($sformatf("rnd if bundle a=%0h", a), if_bundle, ref_bundle(a));
          if_req = 0;
        end
      end
    join
    mon_on = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Sequencer and arbiter in front of the single-port unified instruction/data memory of the pipelined RV32I core. It shares the memory between two requesters: the IF stage, which fetches a 96-bit bundle of three instructions, and the MEM stage, which issues byte, half and word loads and stores. Each access is a two-cycle issue/response transaction. MEM has priority; a bounded starvation counter guarantees forward progress for IF. Stores into the instruction region are blocked and flagged.

## Interface
- ADDR_W, 12, byte-address width to memory
- INSTR_END, 2048, first data-region byte address; instruction region is addr < INSTR_END
- STARVE_MAX, 4, consecutive MEM grants while IF waits before IF is forced
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; if_addr held stable until if_done or if_flush
- if_addr  in  ADDR_W  fetch byte address
- if_flush  in  1  cancel outstanding fetch response (branch/jump redirect)
- if_done  out  1  one-cycle pulse: if_bundle valid
- if_bundle  out  96  registered 12-byte bundle, instr0 in [31:0]
- d_req  in  1  data request; d_* held stable until d_done
- d_addr  in  ADDR_W  data byte address
- d_read  in  2  01 LB/LBU, 10 LH/LHU, 11 LW, 00 none
- d_write  in  2  01 SB, 10 SH, 11 SW, 00 none
- d_unsigned  in  1  zero-extend load
- d_wdata  in  32  store data
- d_done  out  1  one-cycle pulse: access complete, d_rdata valid for loads
- d_rdata  out  32  registered load result
- d_fault  out  1  pulse with d_done: store to instruction region was suppressed
- mem_address  out  ADDR_W  to memory address
- mem_read  out  2  to memory MemRead
- mem_write  out  2  to memory MemWrite
- mem_writedata  out  32  to memory writedata
- mem_unsigned  out  1  to memory mem_unsigned
- mem_ifetch  out  1  to memory is_instruction_fetch
- mem_rdata  in  96  from memory read_data (combinational read)

## Operation
- States: IDLE, IF_RESP, D_RESP. Reset → IDLE.
- IDLE arbitration:
  - If d_req and (!if_req or starve_cnt < STARVE_MAX), grant MEM.
  - Else if if_req, grant IF.
  - Else no grant; memory controls are 0.
- MEM grant:
  - Drive mem_address=d_addr, mem_read=d_read, mem_write=d_write, mem_writedata=d_wdata, mem_unsigned=d_unsigned, mem_ifetch=0.
  - If d_write≠0 and d_addr < INSTR_END, force mem_write=00 and set the fault flag.
  - At the edge: capture mem_rdata[31:0] into d_rdata, go to D_RESP.
- IF grant:
  - Drive mem_address=if_addr, mem_read=11, mem_write=00, mem_ifetch=1.
  - At the edge: capture mem_rdata into if_bundle, go to IF_RESP.
- IF_RESP: if_done=1 unless if_flush is high this cycle or was high in the grant cycle; then if_done=0 and the data is dropped. Go to IDLE.
- D_RESP: d_done=1, d_fault=registered fault flag. Go to IDLE.
- In both RESP states all mem_* controls are 0 and requests are ignored.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Cleared on IF grant, or whenever if_req=0 in IDLE.
  - +1 on MEM grant while if_req=1, saturating at STARVE_MAX.
- Requesters must drop or update req in the done cycle. A req still high is re-arbitrated in the following IDLE cycle.
- d_read=00 and d_write=00 with d_req is a legal no-op: it completes with d_done and d_rdata=0.

## Timing
- Latency: request sampled in IDLE at cycle N; done pulse at N+1; next grant possible at N+2. Peak throughput is one access per two cycles.
- Stores commit during the grant cycle.
- Reset values: if_done=0, d_done=0, d_fault=0, if_bundle=0, d_rdata=0, all mem_* = 0, state=IDLE, starve_cnt=0.
- if_bundle and d_rdata hold their value between transactions.
- Reset assertion mid-transaction aborts it immediately. No done pulse is issued. A write presented in the grant cycle before the edge is not guaranteed.
- Simultaneous if_req and d_req: MEM wins until starve_cnt = STARVE_MAX, then IF wins exactly once and the counter clears.
- if_flush in IDLE with no outstanding fetch has no effect.

## Test plan
- Reset: hold rst_n=0 with both reqs high → all outputs 0, no mem_* activity; release → first grant on the next IDLE cycle.
- Fetch: if_req, if_addr=0, memory preloaded with 00a00093/01400113/002081b3 → one cycle later if_done=1, if_bundle=96'h002081b3_01400113_00a00093, mem_ifetch was 1 during the grant.
- Load/store: SW d_addr=2048 d_wdata=32'h8000_00F0, then LB signed at 2048 → d_rdata=32'hFFFF_FFF0; LBU → 32'h0000_00F0; LH at 2050 → 32'hFFFF_8000; d_fault=0 throughout.
- Protection: SW to d_addr=16 → mem_write=00 during the grant, d_done=1 with d_fault=1; a following fetch at 16 returns the original bytes.
- Starvation, STARVE_MAX=4: if_req and d_req held high continuously → grant order MEM,MEM,MEM,MEM,IF,MEM… with a done pulse every second cycle.
- Flush: fetch granted at cycle N with if_flush=1 at N+1 → if_done stays 0 and if_bundle is not used; the next fetch completes normally.
